// File: rtl/ysyx_25020047_pkg.sv
// Shared definitions for the ysyx_25020047 write-back path: write-back
// source encodings, load funct3 codes and the two-state pipe FSM encoding.
package ysyx_25020047_pkg;

    // Write-back data source selected by the upstream stage.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LOAD = 2'd2,
        WB_LINK = 2'd3
    } wb_sel_t;

    // Load size/sign encodings (RISC-V funct3 of the load opcode).
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    // Occupancy of the single output register.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // A write-back source that produces a register value at all.
    function automatic logic sel_writes(input wb_sel_t sel);
        return sel != WB_NONE;
    endfunction

endpackage

// File: rtl/ysyx_25020047_load_fmt.sv
// Combinational load formatter: shifts the addressed field of an aligned
// memory word down to bit 0 and sign/zero-extends it according to funct3.
// With YSYX_25020047_WBU_MISALIGN_EN defined it also reports whether the
// byte offset violates the natural alignment of the access size.
module ysyx_25020047_load_fmt
    import ysyx_25020047_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic [2:0]      funct3_i,
    input  logic [OFFW-1:0] offset_i,
    input  logic [XLEN-1:0] memdata_i,
    output logic [XLEN-1:0] data_o,
`ifdef YSYX_25020047_WBU_MISALIGN_EN
    output logic            misaligned_o,
`endif
    output logic            legal_o
);

    logic [XLEN-1:0] shifted;

    // The addressed byte lands at bit 0 regardless of access size.
    assign shifted = memdata_i >> {offset_i, 3'b000};

    // Extend the field; sizes that do not exist for this XLEN are illegal.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case leaves it unassigned (no latch).
        data_o  = '0;
        legal_o = 1'b0;
        case (funct3_i)
            F3_LB: begin
                data_o  = XLEN'($signed(shifted[7:0]));
                legal_o = 1'b1;
            end
            F3_LH: begin
                data_o  = XLEN'($signed(shifted[15:0]));
                legal_o = 1'b1;
            end
            F3_LW: begin
                data_o  = XLEN'($signed(shifted[31:0]));
                legal_o = 1'b1;
            end
            F3_LD: begin
                if (XLEN == 64) begin
                    data_o  = shifted;
                    legal_o = 1'b1;
                end
            end
            F3_LBU: begin
                data_o  = XLEN'(shifted[7:0]);
                legal_o = 1'b1;
            end
            F3_LHU: begin
                data_o  = XLEN'(shifted[15:0]);
                legal_o = 1'b1;
            end
            F3_LWU: begin
                if (XLEN == 64) begin
                    data_o  = XLEN'(shifted[31:0]);
                    legal_o = 1'b1;
                end
            end
            default: begin
                data_o  = '0;
                legal_o = 1'b0;
            end
        endcase
    end

`ifdef YSYX_25020047_WBU_MISALIGN_EN
    logic [2:0] off3;

    // Offset widened to 3 bits so one set of compares serves XLEN 32 and 64.
    assign off3 = 3'(offset_i);

    // Natural alignment check by access size.
    always_comb begin
        misaligned_o = 1'b0;
        case (funct3_i)
            F3_LH, F3_LHU: misaligned_o = off3[0];
            F3_LW, F3_LWU: misaligned_o = |off3[1:0];
            F3_LD:         misaligned_o = |off3;
            default:       misaligned_o = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/ysyx_25020047_wbu_pipe.sv
// Registered, handshaked write-back stage. One output register holds a
// committed instruction (dnpc, write data, write enable, rd); the regfile
// write and IFU redirect happen on the out_valid/out_ready handshake, and a
// wrapping retired-instruction counter advances on every commit.
// Optional: YSYX_25020047_WBU_MISALIGN_EN adds misaligned load/jump
// detection and the out_exc port.
module ysyx_25020047_wbu_pipe
    import ysyx_25020047_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NR_REG = 32,
    localparam int RW    = $clog2(NR_REG)
) (
    input  logic            clk,
    input  logic            rst_n,
    // Upstream (LSU/EXU) side
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_wb_sel,
    input  logic            in_jump,
    input  logic [2:0]      in_funct3,
    input  logic [RW-1:0]   in_rd,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_memdata,
    input  logic [XLEN-1:0] in_snpc,
    // Commit side (IFU / register file)
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_dnpc,
    output logic            rf_wen,
    output logic [RW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
`ifdef YSYX_25020047_WBU_MISALIGN_EN
    output logic            out_exc,
`endif
    output logic [XLEN-1:0] instret
);

    localparam int OFFW = $clog2(XLEN / 8);

    wb_sel_t         sel;
    logic [0:0]      state_q, state_d;
    logic            accept, commit;

    logic [XLEN-1:0] dnpc_q,  dnpc_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            wen_q,   wen_d;
    logic [RW-1:0]   rd_q;
    logic [XLEN-1:0] instret_q;

    logic [XLEN-1:0] load_data;
    logic            load_legal;
`ifdef YSYX_25020047_WBU_MISALIGN_EN
    logic            load_mis;
    logic            exc_q, exc_d;
`endif

    assign sel = wb_sel_t'(in_wb_sel);

    // Handshakes: in_ready depends only on occupancy and out_ready.
    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = (state_q == ST_EMPTY) | out_ready;
    assign accept    = in_valid & in_ready;
    assign commit    = out_valid & out_ready;

    ysyx_25020047_load_fmt #(
        .XLEN (XLEN)
    ) u_load_fmt (
        .funct3_i     (in_funct3),
        .offset_i     (in_result[OFFW-1:0]),
        .memdata_i    (in_memdata),
        .data_o       (load_data),
`ifdef YSYX_25020047_WBU_MISALIGN_EN
        .misaligned_o (load_mis),
`endif
        .legal_o      (load_legal)
    );

    // Build the entry that is captured on accept.
    always_comb begin
        dnpc_d  = in_jump ? in_result : in_snpc;
        wdata_d = '0;
        wen_d   = sel_writes(sel);
        case (sel)
            WB_ALU:  wdata_d = in_result;
            WB_LINK: wdata_d = in_snpc;
            WB_LOAD: begin
                wdata_d = load_data;
                wen_d   = load_legal;
            end
            default: wdata_d = '0;
        endcase
        // x0 is hard-wired; never strobe a write to it.
        if (in_rd == '0) begin
            wen_d = 1'b0;
        end
`ifdef YSYX_25020047_WBU_MISALIGN_EN
        // A faulting instruction still commits (and redirects) but never
        // writes the register file.
        exc_d = ((sel == WB_LOAD) & load_legal & load_mis) | (in_jump & in_result[1]);
        if (exc_d) begin
            wen_d = 1'b0;
        end
`endif
    end

    // EMPTY/FULL occupancy: a simultaneous commit and accept stays FULL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (commit && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Occupancy register; reset drops any held entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every flop samples the pre-edge values of its neighbours.
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output register: reloaded only on accept, so it holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dnpc_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            rd_q    <= '0;
`ifdef YSYX_25020047_WBU_MISALIGN_EN
            exc_q   <= 1'b0;
`endif
        end else if (accept) begin
            dnpc_q  <= dnpc_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            rd_q    <= in_rd;
`ifdef YSYX_25020047_WBU_MISALIGN_EN
            exc_q   <= exc_d;
`endif
        end
    end

    // Retired-instruction counter; wraps naturally at 2^XLEN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (commit) begin
            instret_q <= instret_q + XLEN'(1);
        end
    end

    // The regfile write coincides with the commit handshake.
    assign rf_wen   = commit & wen_q;
    assign rf_waddr = rd_q;
    assign rf_wdata = wdata_q;
    assign out_dnpc = dnpc_q;
    assign instret  = instret_q;
`ifdef YSYX_25020047_WBU_MISALIGN_EN
    assign out_exc  = exc_q;
`endif

endmodule

// File: tb/tb_ysyx_25020047_wbu_pipe.sv
// Scoreboard bench for ysyx_25020047_wbu_pipe (XLEN=32, NR_REG=32).
// The driver pushes the hand-computed expected commit when an instruction is
// accepted; an independent monitor pops and compares on every commit.
module tb_ysyx_25020047_wbu_pipe;

`ifdef YSYX_25020047_WBU_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, in_jump;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic [31:0] in_result, in_memdata, in_snpc;
    logic        out_valid, out_ready, rf_wen;
    logic [31:0] out_dnpc, rf_wdata, instret;
    logic [4:0]  rf_waddr;
`ifdef YSYX_25020047_WBU_MISALIGN_EN
    logic        out_exc;
`endif

    always #5 clk = ~clk;

    ysyx_25020047_wbu_pipe #(
        .XLEN   (32),
        .NR_REG (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_wb_sel  (in_wb_sel),
        .in_jump    (in_jump),
        .in_funct3  (in_funct3),
        .in_rd      (in_rd),
        .in_result  (in_result),
        .in_memdata (in_memdata),
        .in_snpc    (in_snpc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dnpc   (out_dnpc),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
`ifdef YSYX_25020047_WBU_MISALIGN_EN
        .out_exc    (out_exc),
`endif
        .instret    (instret)
    );

    typedef struct {
        logic [31:0] dnpc;
        logic [31:0] wdata;
        logic        wen;
        logic [4:0]  rd;
        logic        exc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] exp_instret;
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every commit against the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("commit_without_expected", 64'(sb_q.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rf_wen",   64'(rf_wen),   64'(e.wen));
                    check("rf_waddr", 64'(rf_waddr), 64'(e.rd));
                    check("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
                    check("out_dnpc", 64'(out_dnpc), 64'(e.dnpc));
                    check("instret",  64'(instret),  64'(exp_instret));
`ifdef YSYX_25020047_WBU_MISALIGN_EN
                    check("out_exc",  64'(out_exc),  64'(e.exc));
`endif
                    exp_instret = exp_instret + 32'd1;
                end
            end
        end
    end

    // Present one instruction (called at a negedge); returns at the negedge
    // after the accepting edge.
    task automatic send(input logic [1:0] sel, input logic jump, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] result, input logic [31:0] mem,
                        input logic [31:0] snpc, input logic [31:0] e_wdata, input logic e_wen,
                        input logic [31:0] e_dnpc, input logic e_exc);
        int tries = 0;
        exp_t e;
        in_wb_sel  = sel;
        in_jump    = jump;
        in_funct3  = f3;
        in_rd      = rd;
        in_result  = result;
        in_memdata = mem;
        in_snpc    = snpc;
        in_valid   = 1'b1;
        #1;
        while (!in_ready && tries < 50) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
        end else begin
            e.dnpc = e_dnpc; e.wdata = e_wdata; e.wen = e_wen; e.rd = rd; e.exc = e_exc;
            sb_q.push_back(e);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) check("drain_timeout", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        in_valid = 1'b0; in_wb_sel = 2'd0; in_jump = 1'b0; in_funct3 = 3'd0; in_rd = '0;
        in_result = '0; in_memdata = '0; in_snpc = '0; out_ready = 1'b1;
        exp_instret = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_dnpc",  64'(out_dnpc),  64'd0);
        check("rst_rf_wen",    64'(rf_wen),    64'd0);
        check("rst_rf_waddr",  64'(rf_waddr),  64'd0);
        check("rst_rf_wdata",  64'(rf_wdata),  64'd0);
        check("rst_instret",   64'(instret),   64'd0);
`ifdef YSYX_25020047_WBU_MISALIGN_EN
        check("rst_out_exc",   64'(out_exc),   64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back stream: ALU, loads, link, none, illegal, misaligned.
        //   sel jmp f3 rd  result        memdata       snpc           wdata         wen      dnpc          exc
        send(1, 0, 0, 5,  32'h0000_1234, 32'h0,        32'h8000_0004, 32'h0000_1234, 1,      32'h8000_0004, 0);
        send(2, 0, 0, 6,  32'h8000_0013, 32'h80FF_7F01, 32'h8000_0008, 32'hFFFF_FF80, 1,      32'h8000_0008, 0);
        send(2, 0, 4, 7,  32'h8000_0013, 32'h80FF_7F01, 32'h8000_0008, 32'h0000_0080, 1,      32'h8000_0008, 0);
        send(2, 0, 1, 8,  32'h8000_0012, 32'h80FF_7F01, 32'h8000_0008, 32'hFFFF_80FF, 1,      32'h8000_0008, 0);
        send(2, 0, 5, 9,  32'h8000_0012, 32'h80FF_7F01, 32'h8000_0008, 32'h0000_80FF, 1,      32'h8000_0008, 0);
        send(2, 0, 2, 10, 32'h8000_0010, 32'h80FF_7F01, 32'h8000_0008, 32'h80FF_7F01, 1,      32'h8000_0008, 0);
        send(2, 0, 0, 11, 32'h8000_0011, 32'h80FF_7F01, 32'h8000_0008, 32'h0000_007F, 1,      32'h8000_0008, 0);
        send(3, 1, 0, 1,  32'h8000_0100, 32'h0,        32'h8000_0008, 32'h8000_0008, 1,      32'h8000_0100, 0);
        send(3, 1, 0, 0,  32'h8000_0100, 32'h0,        32'h8000_0008, 32'h8000_0008, 0,      32'h8000_0100, 0);
        send(0, 0, 0, 3,  32'h0000_0055, 32'h0,        32'h8000_000C, 32'h0000_0000, 0,      32'h8000_000C, 0);
        send(2, 0, 7, 4,  32'h8000_0010, 32'h80FF_7F01, 32'h8000_0010, 32'h0000_0000, 0,      32'h8000_0010, 0);
        send(2, 0, 3, 4,  32'h8000_0010, 32'h80FF_7F01, 32'h8000_0010, 32'h0000_0000, 0,      32'h8000_0010, 0);
        send(2, 0, 6, 4,  32'h8000_0010, 32'h80FF_7F01, 32'h8000_0010, 32'h0000_0000, 0,      32'h8000_0010, 0);
        send(2, 0, 2, 12, 32'h8000_0002, 32'h80FF_7F01, 32'h8000_0014, 32'h0000_80FF, !MIS_EN, 32'h8000_0014, MIS_EN);
        send(2, 0, 1, 13, 32'h8000_0001, 32'h80FF_7F01, 32'h8000_0014, 32'hFFFF_FF7F, !MIS_EN, 32'h8000_0014, MIS_EN);
        send(1, 1, 0, 2,  32'h8000_0102, 32'h0,        32'h8000_0018, 32'h8000_0102, !MIS_EN, 32'h8000_0102, MIS_EN);
        drain();

        // Backpressure: A held for 3 cycles while B waits, then commit+accept.
        out_ready = 1'b0;
        send(1, 0, 0, 14, 32'h0000_AAAA, 32'h0, 32'h8000_0020, 32'h0000_AAAA, 1, 32'h8000_0020, 0);
        in_wb_sel = 2'd1; in_jump = 1'b0; in_funct3 = 3'd0; in_rd = 5'd15;
        in_result = 32'h0000_BBBB; in_memdata = '0; in_snpc = 32'h8000_0024;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready",  64'(in_ready),  64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_rf_wen",    64'(rf_wen),    64'd0);
            check("bp_out_dnpc",  64'(out_dnpc),  64'h8000_0020);
            check("bp_rf_wdata",  64'(rf_wdata),  64'h0000_AAAA);
            check("bp_rf_waddr",  64'(rf_waddr),  64'd14);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        begin
            exp_t eb;
            eb.dnpc = 32'h8000_0024; eb.wdata = 32'h0000_BBBB; eb.wen = 1'b1; eb.rd = 5'd15; eb.exc = 1'b0;
            sb_q.push_back(eb);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("bp_second_valid", 64'(out_valid), 64'd1);
        check("bp_second_wdata", 64'(rf_wdata),  64'h0000_BBBB);
        @(negedge clk);
        drain();

        // Counter wrap from all-ones.
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        exp_instret = 32'hFFFF_FFFF;
        @(negedge clk);
        send(1, 0, 0, 16, 32'h0000_0042, 32'h0, 32'h8000_0030, 32'h0000_0042, 1, 32'h8000_0030, 0);
        drain();
        #1;
        check("instret_wrapped", 64'(instret), 64'd0);
        @(negedge clk);

        // Reset while FULL discards the entry with no write.
        out_ready = 1'b0;
        send(1, 0, 0, 20, 32'h0000_0777, 32'h0, 32'h8000_0040, 32'h0000_0777, 1, 32'h8000_0040, 0);
        #1;
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_rf_wen",    64'(rf_wen),    64'd0);
        check("mid_rst_out_dnpc",  64'(out_dnpc),  64'd0);
        check("mid_rst_instret",   64'(instret),   64'd0);
        sb_q.delete();
        exp_instret = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1, 0, 0, 21, 32'h0000_0099, 32'h0, 32'h8000_0044, 32'h0000_0099, 1, 32'h8000_0044, 0);
        drain();
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
